// File: rtl/issue_select_if.sv
// Handshake bundle between dispatch/wakeup, the issue select stage and the functional units.
interface issue_select_if #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  parameter int RW       = $clog2(NUM_ROWS),
  parameter int FW       = $clog2(NUM_FUS)
);
  logic                  alloc_en;
  logic [RW-1:0]         alloc_row;
  logic [FW-1:0]         alloc_fu;
  logic [NUM_ROWS-1:0]   request_vector;
  logic [NUM_FUS-1:0]    fu_ready;
  logic [NUM_FUS-1:0]    grant_valid;
  logic [NUM_FUS*RW-1:0] grant_row;
  logic [NUM_ROWS-1:0]   select_vector;
  logic                  free_en;
  logic [RW-1:0]         free_row;
  logic                  alloc_err;

  modport master (
    output alloc_en, alloc_row, alloc_fu, request_vector, fu_ready,
    input  grant_valid, grant_row, select_vector, free_en, free_row, alloc_err
  );

  modport slave (
    input  alloc_en, alloc_row, alloc_fu, request_vector, fu_ready,
    output grant_valid, grant_row, select_vector, free_en, free_row, alloc_err
  );
endinterface

// File: rtl/issue_select_logic.sv
// Oldest-first issue select per functional unit using an age matrix, with a one-row-per-cycle
// drain of granted rows back to the wakeup free-entry FIFO.
module issue_select_logic #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4,
  localparam int RW = $clog2(NUM_ROWS),
  localparam int FW = $clog2(NUM_FUS)
) (
  input logic           clk,
  input logic           rst,
  issue_select_if.slave bus
);

  logic [1:0]            rst_sync_r;
  logic                  rst_int_n_s;

  logic [NUM_ROWS-1:0]   valid_r;
  logic [NUM_ROWS-1:0]   pending_free_r;
  logic [FW-1:0]         fu_of_r  [NUM_ROWS];
  logic [NUM_ROWS-1:0]   age_r    [NUM_ROWS];

  logic [NUM_FUS-1:0]    grant_valid_r;
  logic [NUM_FUS*RW-1:0] grant_row_r;
  logic [NUM_ROWS-1:0]   select_vector_r;
  logic                  free_en_r;
  logic [RW-1:0]         free_row_r;
  logic                  alloc_err_r;

  logic [NUM_ROWS-1:0]   age_col_s [NUM_ROWS];
  logic [NUM_ROWS-1:0]   cand_s    [NUM_FUS];
  logic [NUM_ROWS-1:0]   win_s     [NUM_FUS];
  logic [RW-1:0]         win_idx_s [NUM_FUS];
  logic [NUM_FUS-1:0]    grant_s;
  logic [NUM_ROWS-1:0]   granted_rows_s;
  logic [NUM_ROWS-1:0]   drain_hot_s;
  logic [RW-1:0]         drain_idx_s;
  logic [NUM_ROWS-1:0]   alloc_hot_s;
  logic                  alloc_ok_s;
  logic                  alloc_bad_s;

  function automatic logic [RW-1:0] lowest_idx(input logic [NUM_ROWS-1:0] vec);
    logic [RW-1:0] idx;
    idx = {RW{1'b0}};
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      idx = vec[i] ? RW'(i) : idx;
    end
    return idx;
  endfunction

  function automatic logic [NUM_ROWS-1:0] lowest_hot(input logic [NUM_ROWS-1:0] vec);
    return vec & (~vec + {{(NUM_ROWS-1){1'b0}}, 1'b1});
  endfunction

  // Reset synchronizer: assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  assign alloc_hot_s = {{(NUM_ROWS-1){1'b0}}, 1'b1} << bus.alloc_row;
  assign alloc_ok_s  = bus.alloc_en & ~(|((valid_r | pending_free_r) & alloc_hot_s));
  assign alloc_bad_s = bus.alloc_en & ~alloc_ok_s;
  assign drain_hot_s = lowest_hot(pending_free_r);
  assign drain_idx_s = lowest_idx(pending_free_r);

  // Transpose the age matrix: age_col_s[i][j] set when row j is older than row i.
  always_comb begin
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_ROWS; j++) begin
        age_col_s[i][j] = age_r[j][i];
      end
    end
  end

  // Per-FU arbitration: a candidate wins when no other candidate of that FU is older.
  always_comb begin
    granted_rows_s = {NUM_ROWS{1'b0}};
    grant_s        = {NUM_FUS{1'b0}};
    for (int f = 0; f < NUM_FUS; f++) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        cand_s[f][i] = bus.request_vector[i] & valid_r[i] & ~pending_free_r[i]
                       & (fu_of_r[i] == FW'(f));
      end
      for (int i = 0; i < NUM_ROWS; i++) begin
        win_s[f][i] = cand_s[f][i] & ~(|(cand_s[f] & age_col_s[i]));
      end
      win_idx_s[f]   = lowest_idx(win_s[f]);
      grant_s[f]     = bus.fu_ready[f] & (|win_s[f]);
      granted_rows_s = granted_rows_s | (win_s[f] & {NUM_ROWS{grant_s[f]}});
    end
  end

  // Entry state: allocation, grant retirement, pending-free drain and age ordering.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      valid_r        <= {NUM_ROWS{1'b0}};
      pending_free_r <= {NUM_ROWS{1'b0}};
      for (int i = 0; i < NUM_ROWS; i++) begin
        fu_of_r[i] <= {FW{1'b0}};
        age_r[i]   <= {NUM_ROWS{1'b0}};
      end
    end else begin
      valid_r        <= (valid_r & ~granted_rows_s) | (alloc_hot_s & {NUM_ROWS{alloc_ok_s}});
      pending_free_r <= (pending_free_r & ~drain_hot_s) | granted_rows_s;
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (alloc_ok_s && alloc_hot_s[i]) begin
          fu_of_r[i] <= bus.alloc_fu;
        end
        // The new row is younger than every currently valid row and older than none.
        for (int j = 0; j < NUM_ROWS; j++) begin
          if (alloc_ok_s && alloc_hot_s[i]) begin
            age_r[i][j] <= 1'b0;
          end else if (alloc_ok_s && alloc_hot_s[j]) begin
            age_r[i][j] <= valid_r[i];
          end
        end
      end
    end
  end

  // Registered outputs: one-cycle grant pulses, drain port and sticky allocation error.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      grant_valid_r   <= {NUM_FUS{1'b0}};
      grant_row_r     <= {(NUM_FUS*RW){1'b0}};
      select_vector_r <= {NUM_ROWS{1'b0}};
      free_en_r       <= 1'b0;
      free_row_r      <= {RW{1'b0}};
      alloc_err_r     <= 1'b0;
    end else begin
      grant_valid_r <= grant_s;
      for (int f = 0; f < NUM_FUS; f++) begin
        grant_row_r[RW*f +: RW] <= grant_s[f] ? win_idx_s[f] : {RW{1'b0}};
      end
      select_vector_r <= granted_rows_s;
      free_en_r       <= |pending_free_r;
      free_row_r      <= drain_idx_s;
      alloc_err_r     <= alloc_err_r | alloc_bad_s;
    end
  end

  assign bus.grant_valid   = grant_valid_r;
  assign bus.grant_row     = grant_row_r;
  assign bus.select_vector = select_vector_r;
  assign bus.free_en       = free_en_r;
  assign bus.free_row      = free_row_r;
  assign bus.alloc_err     = alloc_err_r;

  issue_select_checker #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_FUS  (NUM_FUS)
  ) u_checker (
    .clk           (clk),
    .rst_n         (rst_int_n_s),
    .valid         (valid_r),
    .pending_free  (pending_free_r),
    .grant_valid   (grant_valid_r),
    .select_vector (select_vector_r)
  );

endmodule

// Invariants of the select stage: a row is never both live and awaiting free,
// and every grant pulse contributes exactly one distinct row to select_vector.
module issue_select_checker #(
  parameter int NUM_ROWS = 8,
  parameter int NUM_FUS  = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic [NUM_ROWS-1:0] valid,
  input logic [NUM_ROWS-1:0] pending_free,
  input logic [NUM_FUS-1:0]  grant_valid,
  input logic [NUM_ROWS-1:0] select_vector
);

  a_valid_pending_disjoint: assert property (
    @(posedge clk) disable iff (!rst_n) ((valid & pending_free) == {NUM_ROWS{1'b0}})
  );

  a_select_matches_grants: assert property (
    @(posedge clk) disable iff (!rst_n) ($countones(select_vector) == $countones(grant_valid))
  );

endmodule

// File: tb/tb_issue_select_logic.sv
// Self-checking bench for issue_select_logic: directed scenarios plus random traffic against an
// allocation-timestamp reference model (oldest = smallest stamp, drain = lowest pending row).
module tb_issue_select_logic;
  localparam int NR = 8;
  localparam int NF = 4;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_select_if #(.NUM_ROWS(NR), .NUM_FUS(NF)) ifc ();

  issue_select_logic #(.NUM_ROWS(NR), .NUM_FUS(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  bit m_valid [NR];
  int m_fu    [NR];
  int m_stamp [NR];
  bit m_pend  [NR];
  bit m_err;
  int stamp_ctr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_fu[i]    = 0;
      m_stamp[i] = 0;
      m_pend[i]  = 1'b0;
    end
    m_err     = 1'b0;
    stamp_ctr = 0;
  endtask

  task automatic drive_idle();
    ifc.alloc_en       = 1'b0;
    ifc.alloc_row      = 3'd0;
    ifc.alloc_fu       = 2'd0;
    ifc.request_vector = 8'h00;
    ifc.fu_ready       = 4'hF;
  endtask

  // One clock: predict from model + current inputs, advance the model, then compare.
  task automatic step();
    logic [NF-1:0] e_gv;
    int            e_gr [NF];
    logic [NR-1:0] e_sel;
    bit            e_fen;
    int            e_frow;
    int            best;
    bit            ok;
    int            row;
    e_gv   = '0;
    e_sel  = '0;
    e_fen  = 1'b0;
    e_frow = 0;
    for (int f = 0; f < NF; f++) begin
      e_gr[f] = 0;
      best    = -1;
      for (int i = 0; i < NR; i++) begin
        if (ifc.request_vector[i] && m_valid[i] && !m_pend[i] && m_fu[i] == f) begin
          if (best < 0 || m_stamp[i] < m_stamp[best]) best = i;
        end
      end
      if (best >= 0 && ifc.fu_ready[f]) begin
        e_gv[f]     = 1'b1;
        e_gr[f]     = best;
        e_sel[best] = 1'b1;
      end
    end
    for (int i = NR - 1; i >= 0; i--) begin
      if (m_pend[i]) begin
        e_fen  = 1'b1;
        e_frow = i;
      end
    end
    row = int'(ifc.alloc_row);
    ok  = ifc.alloc_en && !m_valid[row] && !m_pend[row];
    if (ifc.alloc_en && !ok) m_err = 1'b1;
    if (e_fen) m_pend[e_frow] = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (e_sel[i]) begin
        m_valid[i] = 1'b0;
        m_pend[i]  = 1'b1;
      end
    end
    if (ok) begin
      m_valid[row] = 1'b1;
      m_fu[row]    = int'(ifc.alloc_fu);
      m_stamp[row] = stamp_ctr;
      stamp_ctr++;
    end
    @(posedge clk);
    #1;
    check("grant_valid", 32'(ifc.grant_valid), 32'(e_gv));
    for (int f = 0; f < NF; f++) begin
      if (e_gv[f]) check($sformatf("grant_row%0d", f), 32'(ifc.grant_row[RW*f +: RW]), 32'(e_gr[f]));
    end
    check("select_vector", 32'(ifc.select_vector), 32'(e_sel));
    check("free_en", 32'(ifc.free_en), 32'(e_fen));
    if (e_fen) check("free_row", 32'(ifc.free_row), 32'(e_frow));
    check("alloc_err", 32'(ifc.alloc_err), 32'(m_err));
  endtask

  task automatic alloc(input int row, input int fu);
    ifc.alloc_en  = 1'b1;
    ifc.alloc_row = 3'(row);
    ifc.alloc_fu  = 2'(fu);
    step();
    ifc.alloc_en  = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      ifc.alloc_en       = 1'($urandom);
      ifc.alloc_row      = 3'($urandom);
      ifc.alloc_fu       = 2'($urandom);
      ifc.request_vector = 8'($urandom);
      ifc.fu_ready       = 4'($urandom);
      @(posedge clk);
      #1;
      check("rst_grant_valid", 32'(ifc.grant_valid), 32'd0);
      check("rst_grant_row", 32'(ifc.grant_row), 32'd0);
      check("rst_select", 32'(ifc.select_vector), 32'd0);
      check("rst_free_en", 32'(ifc.free_en), 32'd0);
      check("rst_free_row", 32'(ifc.free_row), 32'd0);
      check("rst_alloc_err", 32'(ifc.alloc_err), 32'd0);
    end
    drive_idle();
    rst = 1'b1;
    idle_steps(3);
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    model_reset();
    do_reset();

    // Age ordering: 5, 2, 7 allocated in that order on FU0.
    alloc(5, 0);
    alloc(2, 0);
    alloc(7, 0);
    step();
    ifc.request_vector = 8'hA4;
    step();
    check("age_first", 32'(ifc.grant_row[2:0]), 32'd5);
    step();
    check("age_second", 32'(ifc.grant_row[2:0]), 32'd2);
    step();
    check("age_third", 32'(ifc.grant_row[2:0]), 32'd7);
    ifc.request_vector = 8'h00;
    idle_steps(4);

    // Stall: FU1 not ready for three cycles.
    alloc(3, 1);
    ifc.request_vector = 8'h08;
    ifc.fu_ready       = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_no_grant", 32'(ifc.grant_valid[1]), 32'd0);
    end
    ifc.fu_ready = 4'hF;
    step();
    check("stall_grant", 32'(ifc.grant_valid[1]), 32'd1);
    check("stall_select", 32'(ifc.select_vector), 32'h08);
    ifc.request_vector = 8'h00;
    idle_steps(3);

    // Parallel: four FUs in one cycle, then a four-cycle drain.
    for (int r = 0; r < 4; r++) alloc(r, r);
    ifc.request_vector = 8'h0F;
    step();
    check("par_grants", 32'(ifc.grant_valid), 32'hF);
    check("par_select", 32'(ifc.select_vector), 32'h0F);
    ifc.request_vector = 8'h00;
    for (int r = 0; r < 4; r++) begin
      step();
      check("par_free_en", 32'(ifc.free_en), 32'd1);
      check("par_free_row", 32'(ifc.free_row), 32'(r));
    end
    step();
    check("par_drained", 32'(ifc.free_en), 32'd0);

    // Reset in the middle of a drain drops the remaining frees.
    for (int r = 0; r < 4; r++) alloc(r, r);
    ifc.request_vector = 8'h0F;
    step();
    ifc.request_vector = 8'h00;
    idle_steps(2);
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_free_en", 32'(ifc.free_en), 32'd0);
    check("mid_rst_grant", 32'(ifc.grant_valid), 32'd0);
    check("mid_rst_select", 32'(ifc.select_vector), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_steps(6);

    // Allocation into a row that is awaiting free.
    alloc(6, 2);
    ifc.request_vector = 8'h40;
    step();
    ifc.request_vector = 8'h00;
    alloc(6, 3);
    check("err_pending", 32'(ifc.alloc_err), 32'd1);
    idle_steps(2);
    do_reset();

    // Allocation into a live row: FU and age must survive.
    alloc(1, 2);
    alloc(4, 2);
    alloc(1, 0);
    check("err_valid", 32'(ifc.alloc_err), 32'd1);
    ifc.request_vector = 8'h12;
    step();
    check("err_keep_fu", 32'(ifc.grant_valid), 32'h4);
    check("err_keep_age", 32'(ifc.grant_row[8:6]), 32'd1);
    step();
    check("err_second", 32'(ifc.grant_row[8:6]), 32'd4);
    ifc.request_vector = 8'h00;
    idle_steps(3);
    check("err_sticky", 32'(ifc.alloc_err), 32'd1);

    // Random traffic with legal allocations only.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      int r;
      ifc.fu_ready       = 4'($urandom);
      ifc.request_vector = 8'($urandom);
      ifc.alloc_en       = 1'b0;
      r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) != 0 && !m_valid[r] && !m_pend[r]) begin
        ifc.alloc_en  = 1'b1;
        ifc.alloc_row = 3'(r);
        ifc.alloc_fu  = 2'($urandom_range(0, NF - 1));
      end
      step();
    end
    drive_idle();
    idle_steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
